// File: rtl/simon32_64_decrypt_if.sv
// Request/response bundle for the Simon 32/64 decryptor.
// The master side issues start and the operands, and the slave side returns the result.
interface simon32_64_decrypt_if;
  logic        start;
  logic [31:0] ciphertext;
  logic [63:0] keytext;
  logic [31:0] plaintext;
  logic        busy;
  logic        done;

  modport master (
    output start, ciphertext, keytext,
    input  plaintext, busy, done
  );

  modport slave (
    input  start, ciphertext, keytext,
    output plaintext, busy, done
  );
endinterface

// File: rtl/simon32_64_decrypt.sv
// Iterative Simon 32/64 decryptor. It runs the key schedule forward to k28..k31,
// then applies the inverse rounds while it walks the key window back down.
module simon32_64_decrypt (
  input  logic                 clk,
  input  logic                 rst_n,
  simon32_64_decrypt_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, KEXP, DEC, DONE} state_t;

  localparam logic [15:0] c_const = 16'hFFFC;
  localparam logic [0:61] z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

  state_t             state, state_nxt;
  logic [15:0]        x, y;
  logic [3:0][15:0]   kw;
  logic [4:0]         cnt;
  logic [31:0]        pt_q;

  logic [15:0]        fwd_t, fwd_k;
  logic [15:0]        rev_t, rev_k, rev_low;
  logic [4:0]         rev_idx;
  logic [15:0]        round_y;

  function automatic logic [15:0] f(input logic [15:0] v);
    return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
  endfunction

  function automatic logic [15:0] ror1(input logic [15:0] v);
    return {v[0], v[15:1]};
  endfunction

  function automatic logic [15:0] ror3(input logic [15:0] v);
    return {v[2:0], v[15:3]};
  endfunction

  // kw[0] is the oldest word of the window and kw[3] the newest (k[r] while decrypting).
  always_comb begin
    fwd_t   = ror3(kw[3]) ^ kw[1];
    fwd_k   = c_const ^ {15'b0, z0[{1'b0, cnt}]} ^ kw[0] ^ fwd_t ^ ror1(fwd_t);
    rev_idx = cnt - 5'd4;
    rev_t   = ror3(kw[2]) ^ kw[0];
    rev_k   = c_const ^ {15'b0, z0[{1'b0, rev_idx}]} ^ kw[3] ^ rev_t ^ ror1(rev_t);
    rev_low = (cnt >= 5'd4) ? rev_k : 16'h0;
    round_y = x ^ f(y) ^ kw[3];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = KEXP;
      KEXP: if (cnt == 5'd27) state_nxt = DEC;
      DEC:  if (cnt == 5'd0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The counter is shared: it counts up through the key expansion, then down over the rounds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= 16'h0;
      y    <= 16'h0;
      kw   <= '0;
      cnt  <= 5'd0;
      pt_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            x   <= bus.ciphertext[31:16];
            y   <= bus.ciphertext[15:0];
            kw  <= bus.keytext;
            cnt <= 5'd0;
          end
        end
        KEXP: begin
          kw  <= {fwd_k, kw[3:1]};
          cnt <= (cnt == 5'd27) ? 5'd31 : cnt + 5'd1;
        end
        DEC: begin
          x   <= y;
          y   <= round_y;
          kw  <= {kw[2:0], rev_low};
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) pt_q <= {y, round_y};
        end
        default: ;
      endcase
    end
  end

  assign bus.plaintext = pt_q;
  assign bus.busy      = (state == KEXP) || (state == DEC);
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_simon32_64_decrypt.sv
// Scoreboard bench for simon32_64_decrypt. A plain Simon 32/64 encryptor model produces
// the ciphertexts, and a monitor checks each done pulse against the queued expectation.
module tb_simon32_64_decrypt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  simon32_64_decrypt_if bus ();

  simon32_64_decrypt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pt;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_item;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          busy_run = 0;
  logic [31:0] held_pt = 32'h0;

  localparam logic [63:0] vec_key = 64'h1918111009080100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  // Textbook encryptor: expand all 32 round keys, then run 32 Feistel rounds.
  function automatic logic [31:0] encryptModel(input logic [63:0] key, input logic [31:0] pt);
    logic [61:0] zbits;
    logic [15:0] k [32];
    logic [15:0] t, xx, yy, tmp;
    zbits = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t    = rotl(k[i-1], 13) ^ k[i-3];
      t    = t ^ rotl(t, 15);
      k[i] = ~k[i-4] ^ t ^ {15'b0, zbits[61-(i-4)]} ^ 16'h0003;
    end
    xx = pt[31:16];
    yy = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      tmp = xx;
      xx  = yy ^ (rotl(xx, 1) & rotl(xx, 8)) ^ rotl(xx, 2) ^ k[i];
      yy  = tmp;
    end
    return {xx, yy};
  endfunction

  task automatic applyStimulus(input logic [63:0] key, input logic [31:0] ct,
                               input logic [31:0] exp_pt, input bit hold);
    @(negedge clk);
    bus.keytext    = key;
    bus.ciphertext = ct;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("busy_after_accept", 64'(bus.busy), 64'd1);
    sb.push_back(exp_t'{exp_pt, cyc + 60});
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  // The monitor pops one expectation per done pulse. Plaintext must not move while busy.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_pt  = 32'h0;
      busy_run = 0;
    end else begin
      if (bus.busy) begin
        busy_run++;
        checkOutput("pt_hold", 64'(bus.plaintext), 64'(held_pt));
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_done", 64'd1, 64'd0);
        end else begin
          mon_item = sb.pop_front();
          checkOutput("plaintext", 64'(bus.plaintext), 64'(mon_item.pt));
          checkOutput("done_cycle", 64'(cyc), 64'(mon_item.cyc));
          checkOutput("busy_len", 64'(busy_run), 64'd60);
        end
        held_pt  = bus.plaintext;
        busy_run = 0;
      end else if (!bus.busy) begin
        busy_run = 0;
      end
    end
  end

  initial begin
    logic [63:0] key;
    logic [31:0] pt;
    logic [31:0] rt_pts [3];
    rt_pts[0] = 32'h41424344;
    rt_pts[1] = 32'h345A6B7C;
    rt_pts[2] = 32'h78569043;

    bus.start      = 1'b0;
    bus.ciphertext = 32'h0;
    bus.keytext    = 64'h0;
    #1;
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkOutput("reset_pt", 64'(bus.plaintext), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] known answer vector");
    applyStimulus(vec_key, 32'hC69BE9BB, 32'h65656877, 1'b0);
    waitDrain(100);

    $display("[TB] round trips");
    foreach (rt_pts[i]) begin
      applyStimulus(vec_key, encryptModel(vec_key, rt_pts[i]), rt_pts[i], 1'b0);
      waitDrain(100);
    end

    $display("[TB] start during operation is ignored");
    pt = 32'h13572468;
    applyStimulus(vec_key, encryptModel(vec_key, pt), pt, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.ciphertext = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitDrain(100);
    repeat (70) @(posedge clk);
    #1;
    checkOutput("no_queued_start", 64'(bus.busy), 64'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(vec_key, 32'hC69BE9BB, 32'h65656877, 1'b0);
    repeat (39) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_done", 64'(bus.done), 64'd0);
    checkOutput("abort_pt", 64'(bus.plaintext), 64'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(posedge clk);
    applyStimulus(vec_key, 32'hC69BE9BB, 32'h65656877, 1'b0);
    waitDrain(100);

    $display("[TB] start held across two operations");
    pt = 32'hCAFE0123;
    applyStimulus(vec_key, 32'hC69BE9BB, 32'h65656877, 1'b1);
    bus.ciphertext = encryptModel(vec_key, pt);
    sb.push_back(exp_t'{pt, cyc + 62 + 60});
    repeat (62) @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitDrain(200);

    $display("[TB] inputs change after accept");
    key = {$urandom, $urandom};
    pt  = $urandom;
    applyStimulus(key, encryptModel(key, pt), pt, 1'b0);
    @(posedge clk);
    #1;
    bus.ciphertext = $urandom;
    bus.keytext    = {$urandom, $urandom};
    waitDrain(100);

    $display("[TB] random operations");
    for (int n = 0; n < 5; n++) begin
      key = {$urandom, $urandom};
      pt  = $urandom;
      applyStimulus(key, encryptModel(key, pt), pt, 1'b0);
      waitDrain(100);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
